pwm_cfg_arbiter: RTL and testbench
==================================

# pwm_cfg_arbiter

Shares the single `pwm` phase-accumulator generator between up to NREQ LED pattern sources (breath, blink, host register, fault indicator). Each source holds a request while it needs the LED. The arbiter grants ownership round-robin, enforces a minimum dwell per owner, and drives the shared `period`/`duty` configuration. It sits between the pattern engines and the `pwm` instance, and replaces direct per-engine wiring of `period`/`duty`.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 32, period/duty width; matches the `pwm` N
- HOLD_CYCLES, 2700, minimum ownership dwell in clk cycles before preemption (100 us at 27 MHz)
- IDLE_DUTY, 32'h0, duty driven when no owner (LED off)

Ports:
- clk  in  1  system clock, 27 MHz
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  level request per source; held high while ownership is wanted
- period_in  in  NREQ*N  packed per-source period; source i occupies bits [i*N +: N]
- duty_in  in  NREQ*N  packed per-source duty, same packing
- gnt  out  NREQ  one-hot grant; all-zero when no owner
- owner  out  3  index of the current owner; valid only when busy=1
- busy  out  1  an owner is installed
- period  out  N  to `pwm.period`
- duty  out  N  to `pwm.duty`

## Operation
- States: IDLE, OWN, GAP.
- IDLE: gnt=0, busy=0, period=0, duty=IDLE_DUTY. If any req bit is set, pick the winner by rotating priority starting at `ptr`, then go to OWN.
- OWN: gnt[owner]=1. period/duty are registered copies of the owner's slice, refreshed every cycle. hold_cnt increments and saturates at HOLD_CYCLES.
  - req[owner]=0 → GAP (release).
  - hold_cnt==HOLD_CYCLES and any other req bit set → GAP (preempt).
  - Otherwise stay in OWN.
- GAP: exactly one cycle with gnt=0, busy=0, period=0, duty=IDLE_DUTY. This quiesces the LED between owners. Then re-arbitrate exactly as IDLE does: go to OWN if any req is set, else go to IDLE.
- Round-robin pointer `ptr` (width clog2 NREQ) is set to owner+1 modulo NREQ on each entry to OWN. The current owner therefore has the lowest priority at the next arbitration.
- A preempted owner keeping req high stays eligible and is re-granted in its turn.
- The winner is chosen only from bits set in the cycle arbitration occurs. req pulses shorter than that cycle are not latched.
- hold_cnt clears on every entry to OWN.
- Simultaneous release and preempt condition: treat as release. The path is the same (GAP).
- NREQ=1: the source is never preempted; it passes through GAP only on release.

## Timing
- Reset (async): state=IDLE, gnt=0, owner=0, busy=0, period=0, duty=IDLE_DUTY, ptr=0, hold_cnt=0.
- Grant latency: req sampled high at edge t in IDLE → gnt, busy, owner, period, duty valid after edge t+1.
- Update latency while owning: change on period_in/duty_in before edge t → visible on period/duty after edge t.
- Release latency: req[owner] low at edge t → gnt=0 after edge t. The next owner is granted after edge t+1.
- Preemption: earliest gnt drop is HOLD_CYCLES+1 cycles after the grant edge.
- rst asserted mid-OWN drops gnt and outputs immediately (asynchronously).

## Configuration
- PWM_ARB_PRIORITY_EN defined: requester 0 is urgent (fault indicator).
  - It always wins arbitration regardless of `ptr`.
  - When req[0] rises while another source owns, that owner is preempted at once (→ GAP) without waiting for HOLD_CYCLES.
  - While requester 0 owns, it is never preempted.
- PWM_ARB_PRIORITY_EN undefined: pure round-robin with dwell, as above. No special handling of requester 0.

## Structure
- Shared package `pwm_arb_pkg`: state encoding (IDLE=0, OWN=1, GAP=2), the owner index width, and the IDLE_DUTY default.
- One sub-module, `rr_pick`: a combinational rotating-priority encoder. It takes (req, ptr) and returns (found, index). It is instantiated once.
- The top contains the FSM, hold counter, pointer, and output registers.

## Test plan
- Reset then req=4'b0010 at cycle 5 → gnt=4'b0010, owner=1 at cycle 6, period/duty equal slice 1 (e.g. 31815 / 32'h6fffffff).
- req=4'b0101 held, HOLD_CYCLES=16 → owner 0 for 17 cycles, then 1 GAP cycle with duty=IDLE_DUTY, then owner 2 for 17 cycles, then owner 0 again.
- Owner 1 drops req after 3 cycles with req[3] high → gnt=0 for one cycle, then gnt=4'b1000. No hold wait occurs.
- Owner changes duty_in mid-ownership from 32'h80000000 to 32'hA0000000 → duty output follows exactly one cycle later. gnt is unchanged.
- rst pulsed during OWN → gnt, busy, and period clear without a clock edge. After release, arbitration restarts from ptr=0.
- With PWM_ARB_PRIORITY_EN: owner 2 at hold_cnt=3, req[0] rises → GAP next cycle, then gnt=4'b0001. req[2] high throughout never preempts owner 0.

Source files
------------

// File: rtl/pwm_arb_pkg.sv
// Shared definitions for the PWM configuration arbiter: FSM encoding, owner index width,
// idle duty default and an index-width helper.
package pwm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    localparam int OWNER_W = 3;

    localparam logic [31:0] IDLE_DUTY_DFLT = 32'h0;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_cfg_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: the first set request at or after ptr_i wins,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             found_o,
    output logic [PTR_W-1:0] idx_o
);

    logic [NREQ-1:0]   rot;
    logic [2*NREQ-1:0] dbl;

    // Rotate so bit 0 of rot is the requester at ptr_i.
    assign dbl = {req_i, req_i} >> ptr_i;
    assign rot = dbl[NREQ-1:0];

    always_comb begin
        int sum;
        found_o = 1'b0;
        idx_o   = '0;
        sum     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                sum     = int'(ptr_i) + i;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                idx_o = PTR_W'(sum);
            end
        end
    end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Round-robin owner arbiter for the shared pwm period/duty configuration with minimum dwell.
// Define PWM_ARB_PRIORITY_EN to make requester 0 urgent (always wins, preempts at once).
module pwm_cfg_arbiter
    import pwm_arb_pkg::*;
#(
    parameter int             NREQ        = 4,
    parameter int             N           = 32,
    parameter int             HOLD_CYCLES = 2700,
    parameter logic [N-1:0]   IDLE_DUTY   = N'(IDLE_DUTY_DFLT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*N-1:0]   period_in_i,
    input  logic [NREQ*N-1:0]   duty_in_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [OWNER_W-1:0]  owner_o,
    output logic                busy_o,
    output logic [N-1:0]        period_o,
    output logic [N-1:0]        duty_o
);

    localparam int PTR_W  = idx_w(NREQ);
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [N-1:0]      period_q, period_d;
    logic [N-1:0]      duty_q, duty_d;

    logic [N-1:0]      per_arr [NREQ];
    logic [N-1:0]      dty_arr [NREQ];

    logic              rr_found;
    logic [PTR_W-1:0]  rr_idx;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic              urgent_preempt;
    logic              no_preempt;
    logic              release_c;
    logic              others_c;
    logic              preempt_c;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign per_arr[g] = period_in_i[g*N +: N];
        assign dty_arr[g] = duty_in_i[g*N +: N];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (rr_found),
        .idx_o   (rr_idx)
    );

`ifdef PWM_ARB_PRIORITY_EN
    // Requester 0 (fault indicator) overrides rotation and dwell, and is never displaced.
    assign win_found      = rr_found;
    assign win_idx        = req_i[0] ? '0 : rr_idx;
    assign urgent_preempt = req_i[0] && (owner_q != '0);
    assign no_preempt     = (owner_q == '0);
`else
    assign win_found      = rr_found;
    assign win_idx        = rr_idx;
    assign urgent_preempt = 1'b0;
    assign no_preempt     = 1'b0;
`endif

    // gnt_q is the one-hot of the owner while in OWN, so it doubles as the owner mask.
    assign release_c = ~|(req_i & gnt_q);
    assign others_c  = |(req_i & ~gnt_q);
    assign preempt_c = !no_preempt && (urgent_preempt || ((hold_q == HOLD_MAX) && others_c));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = '0;
        busy_d   = 1'b0;
        period_d = '0;
        duty_d   = IDLE_DUTY;
        case (state_q)
            ST_OWN: begin
                if (release_c || preempt_c) begin
                    state_d = ST_GAP;
                end else begin
                    gnt_d    = gnt_q;
                    busy_d   = 1'b1;
                    period_d = per_arr[owner_q];
                    duty_d   = dty_arr[owner_q];
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                if (win_found) begin
                    state_d  = ST_OWN;
                    owner_d  = win_idx;
                    ptr_d    = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    hold_d   = '0;
                    gnt_d    = NREQ'(1) << win_idx;
                    busy_d   = 1'b1;
                    period_d = per_arr[win_idx];
                    duty_d   = dty_arr[win_idx];
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            period_q <= '0;
            duty_q   <= IDLE_DUTY;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            period_q <= period_d;
            duty_q   <= duty_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign owner_o  = OWNER_W'(owner_q);
    assign busy_o   = busy_q;
    assign period_o = period_q;
    assign duty_o   = duty_q;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Scoreboard bench for pwm_cfg_arbiter: expectations queued at drive time, compared after
// each clock edge.
module tb_pwm_cfg_arbiter;

    localparam int          NREQ = 4;
    localparam int          N    = 32;
    localparam int          HOLD = 16;
    localparam logic [31:0] IDLE = 32'h0000_00AA;

    typedef struct packed {
        logic [3:0]  gnt;
        logic        busy;
        logic [2:0]  owner;
        logic [31:0] period;
        logic [31:0] duty;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  per [4];
    logic [31:0]  dty [4];
    logic [127:0] period_in;
    logic [127:0] duty_in;
    logic [3:0]   gnt;
    logic [2:0]   owner;
    logic         busy;
    logic [31:0]  period;
    logic [31:0]  duty;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign period_in = {per[3], per[2], per[1], per[0]};
    assign duty_in   = {dty[3], dty[2], dty[1], dty[0]};

    always #5 clk = ~clk;

    pwm_cfg_arbiter #(
        .NREQ        (NREQ),
        .N           (N),
        .HOLD_CYCLES (HOLD),
        .IDLE_DUTY   (IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .period_in_i (period_in),
        .duty_in_i   (duty_in),
        .gnt_o       (gnt),
        .owner_o     (owner),
        .busy_o      (busy),
        .period_o    (period),
        .duty_o      (duty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t e_own(input int i);
        exp_t e;
        e.gnt    = 4'(1) << i;
        e.busy   = 1'b1;
        e.owner  = 3'(i);
        e.period = per[i];
        e.duty   = dty[i];
        return e;
    endfunction

    function automatic exp_t e_idle();
        exp_t e;
        e.gnt    = '0;
        e.busy   = 1'b0;
        e.owner  = '0;
        e.period = '0;
        e.duty   = IDLE;
        return e;
    endfunction

    // who < 0: no owner expected after the coming edge
    task automatic step(input logic [3:0] r, input int who);
        @(negedge clk);
        req = r;
        exp_q.push_back((who < 0) ? e_idle() : e_own(who));
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("busy", 32'(busy), 32'(e.busy));
                if (e.busy) chk("owner", 32'(owner), 32'(e.owner));
                chk("period", period, e.period);
                chk("duty", duty, e.duty);
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        per = '{32'd1000, 32'd31815, 32'd2000, 32'd3000};
        dty = '{32'h1111_0000, 32'h6fff_ffff, 32'h8000_0000, 32'h3333_0000};
        rst = 1'b1;
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_period", period, 32'd0);
        chk("rst_duty", duty, IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single requester grant, then release
        repeat (3) step(4'b0000, -1);
        repeat (3) step(4'b0010, 1);
        step(4'b0000, -1);
        step(4'b0000, -1);

        // owner 1 releases after 3 cycles while req[3] waits: one gap, no dwell
        step(4'b0010, 1);
        step(4'b0010, 1);
        step(4'b1010, 1);
        step(4'b1000, -1);
        step(4'b1000, 3);
        step(4'b1000, 3);
        step(4'b0000, -1);
        step(4'b0000, -1);

        // dwell and preemption between two contenders
        repeat (HOLD + 1) step(4'b0101, 0);
        step(4'b0101, -1);
        repeat (HOLD + 1) step(4'b0101, 2);
        step(4'b0101, -1);
        step(4'b0101, 0);
        step(4'b0000, -1);
        step(4'b0000, -1);

        // duty update while owning follows one edge later
        step(4'b0100, 2);
        step(4'b0100, 2);
        @(negedge clk);
        dty[2] = 32'hA000_0000;
        req    = 4'b0100;
        exp_q.push_back(e_own(2));
        step(4'b0100, 2);
        step(4'b0100, 2);
        drain();

        // asynchronous reset mid-ownership
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_owner", 32'(owner), 32'd0);
        chk("arst_period", period, 32'd0);
        chk("arst_duty", duty, IDLE);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 0);
        step(4'b1111, 0);
        step(4'b1110, -1);
        step(4'b1110, 1);
        step(4'b0000, -1);
        step(4'b0000, -1);

`ifdef PWM_ARB_PRIORITY_EN
        // urgent requester 0 preempts owner 2 at hold 3 and is never displaced
        repeat (4) step(4'b0100, 2);
        step(4'b0101, -1);
        repeat (HOLD + 9) step(4'b0101, 0);
        step(4'b0100, -1);
        step(4'b0100, 2);
        step(4'b0000, -1);
        step(4'b0000, -1);
`else
        // requester 0 gets no special treatment: waits out the full dwell
        repeat (4) step(4'b0100, 2);
        repeat (HOLD - 3) step(4'b0101, 2);
        step(4'b0101, -1);
        step(4'b0101, 0);
        step(4'b0000, -1);
        step(4'b0000, -1);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
